// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for RV32M DIV/DIVU/REM/REMU with pipeline hold and one-cycle writeback
module div_seq #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start_i,
  input  logic [2:0]            div_op_i,
  input  logic [XLEN-1:0]       div_dividend_i,
  input  logic [XLEN-1:0]       div_divisor_i,
  input  logic [REG_ADDR_W-1:0] div_rd_addr_i,
  input  logic                  div_flush_i,
  output logic                  div_busy_o,
  output logic                  div_ready_o,
  output logic                  div_we_o,
  output logic [REG_ADDR_W-1:0] div_rd_addr_o,
  output logic [XLEN-1:0]       div_result_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0] quo, rem, dvs, res_q, a_mag, b_mag, fast_res, rem_n, quo_n, calc_res;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0] rem_sh, trial;
  logic want_rem, qneg, rneg, sgn, a_neg, b_neg, dz, ovf, special, accept, last;
  assign sgn      = ~div_op_i[0];
  assign a_neg    = sgn & div_dividend_i[XLEN-1];
  assign b_neg    = sgn & div_divisor_i[XLEN-1];
  assign a_mag    = a_neg ? -div_dividend_i : div_dividend_i;
  assign b_mag    = b_neg ? -div_divisor_i : div_divisor_i;
  assign dz       = div_divisor_i == '0;
  assign ovf      = sgn & (div_dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (div_divisor_i == '1);
  assign special  = dz | ovf;
  assign accept   = (state == IDLE) & div_start_i & div_op_i[2] & ~div_flush_i;
  assign fast_res = div_op_i[1] ? (dz ? div_dividend_i : '0) : (dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});
  // rem < dvs, so rem_sh - dvs lies in [-dvs, dvs) and bit XLEN is a true sign bit
  assign rem_sh   = {rem, quo[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign rem_n    = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_n    = {quo[XLEN-2:0], ~trial[XLEN]};
  assign last     = cnt == CNT_W'(XLEN-1);
  assign calc_res = want_rem ? (rneg ? -rem_n : rem_n) : (qneg ? -quo_n : quo_n);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = special ? DONE : CALC;
    else if (state == CALC) state_nx = div_flush_i ? IDLE : (last ? DONE : CALC);
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q     <= '0;
      want_rem <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      res_q    <= '0;
    end else if (accept) begin
      rd_q     <= div_rd_addr_i;
      want_rem <= div_op_i[1];
      quo      <= a_mag;
      rem      <= '0;
      dvs      <= b_mag;
      cnt      <= '0;
      qneg     <= a_neg ^ b_neg;
      rneg     <= a_neg;
      if (special) res_q <= fast_res;
    end else if (state == CALC) begin
      quo <= quo_n;
      rem <= rem_n;
      cnt <= cnt + 1'b1;
      if (last) res_q <= calc_res;
    end
  assign div_busy_o    = ~rst & (accept | (state == CALC));
  assign div_ready_o   = (state == DONE) & ~div_flush_i;
  assign div_we_o      = div_ready_o & (rd_q != '0);
  assign div_rd_addr_o = rd_q;
  assign div_result_o  = res_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq against an arithmetic RV32M divide model
module tb_div_seq;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] op = 3'b100;
  logic [31:0] a = 0, b = 0;
  logic [4:0] rd = 0;
  logic busy, ready, we;
  logic [4:0] rd_o;
  logic [31:0] res;
  typedef struct packed {logic [4:0] rd; logic [31:0] res;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;

  div_seq dut (
    .clk(clk), .rst(rst), .div_start_i(start), .div_op_i(op),
    .div_dividend_i(a), .div_divisor_i(b), .div_rd_addr_i(rd), .div_flush_i(flush),
    .div_busy_o(busy), .div_ready_o(ready), .div_we_o(we),
    .div_rd_addr_o(rd_o), .div_result_o(res)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return o[1] ? x : 32'hffffffff;
    if (!o[0]) begin
      if (x == 32'h80000000 && y == 32'hffffffff) return o[1] ? 32'h0 : 32'h80000000;
      return o[1] ? sx % sy : sx / sy;
    end
    return o[1] ? x % y : x / y;
  endfunction

  always @(negedge clk)
    if (!rst && ready) begin
      exp_t e;
      if (q.size() == 0) check("spurious_ready", {31'b0, ready}, 0);
      else begin
        e = q.pop_front();
        check("result", res, e.res);
        check("rd", {27'b0, rd_o}, {27'b0, e.rd});
        check("we", {31'b0, we}, {31'b0, e.rd != 0});
      end
    end

  task automatic do_op(logic [2:0] o, logic [31:0] x, logic [31:0] y, logic [4:0] r, int poke);
    int n, nb;
    logic fast;
    fast = (y == 0) || (!o[0] && x == 32'h80000000 && y == 32'hffffffff);
    @(negedge clk);
    op = o; a = x; b = y; rd = r; start = 1;
    #1 check("busy_issue", {31'b0, busy}, 1);
    nb = 1;
    q.push_back('{rd: r, res: model(o, x, y)});
    n = 0;
    do begin
      @(negedge clk);
      start = 0;
      n++;
      if (busy) nb++;
      if (n == poke) begin start = 1; a = ~x; b = 1; rd = ~r; end
    end while (!ready && n < 40);
    check("latency", n, fast ? 1 : 33);
    check("busy_cycles", nb, fast ? 1 : 33);
    @(negedge clk);
    check("ready_pulse", {31'b0, ready}, 0);
  endtask

  initial begin
    logic [1:0] sel;
    logic [1:0] ol;
    logic [31:0] x, y;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_result", res, 0);
    check("rst_rd", {27'b0, rd_o}, 0);
    rst = 0;
    do_op(3'b101, 100, 7, 5, 0);
    do_op(3'b111, 100, 7, 6, 0);
    do_op(3'b100, 32'hfffffff9, 2, 7, 0);
    do_op(3'b110, 32'hfffffff9, 2, 8, 0);
    do_op(3'b101, 32'hffffffff, 1, 9, 0);
    do_op(3'b100, 1234, 0, 10, 0);
    do_op(3'b110, 1234, 0, 11, 0);
    do_op(3'b100, 32'h80000000, 32'hffffffff, 12, 0);
    do_op(3'b110, 32'h80000000, 32'hffffffff, 13, 0);
    @(negedge clk);
    op = 3'b101; a = 1000; b = 3; rd = 3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    #1 check("flush_ready", {31'b0, ready}, 0);
    check("flush_we", {31'b0, we}, 0);
    @(negedge clk);
    flush = 0;
    check("flush_busy", {31'b0, busy}, 0);
    check("flush_ready_next", {31'b0, ready}, 0);
    do_op(3'b101, 1000, 3, 14, 0);
    do_op(3'b101, 50000, 123, 4, 5);
    @(negedge clk);
    op = 3'b100; a = 777; b = 5; rd = 15; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    start = 1;
    #1 check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_ready", {31'b0, ready}, 0);
    check("midrst_we", {31'b0, we}, 0);
    check("midrst_rd", {27'b0, rd_o}, 0);
    check("midrst_result", res, 0);
    @(negedge clk);
    start = 0;
    rst = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) check("late_ready", {31'b0, ready}, 0);
    end
    check("post_rst_busy", {31'b0, busy}, 0);
    do_op(3'b101, 9, 3, 0, 0);
    for (int i = 0; i < 30; i++) begin
      sel = 2'($urandom_range(0, 3));
      ol = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (sel == 0) ? 32'h0 : (sel == 1) ? $urandom_range(1, 15) : (sel == 2) ? -$urandom_range(1, 15) : $urandom;
      if (i == 7) begin x = 32'h80000000; y = 32'hffffffff; end
      do_op({1'b1, ol}, x, y, 5'($urandom), 0);
    end
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
